ahbl_excl_monitor: RTL
======================

# ahbl_excl_monitor

AHB-Lite global exclusive-access monitor placed between the output of the bus arbiter and a single memory slave. Holds one reservation per master, reports exclusive success on `src_hexokay`, and suppresses failed exclusive (store-conditional) writes by issuing IDLE downstream. All other transfers pass through unchanged with no added latency.

## Interface
- `N_MASTERS`, 2: number of reservation entries, indexed by `hmaster`.
- `W_ADDR`, 32: address width.
- `W_DATA`, 32: data width.
- `GRANULE_LOG2`, 2: log2 of reservation granule in bytes. Addresses are compared on `haddr[W_ADDR-1:GRANULE_LOG2]`.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `src_hready`  in  1  upstream HREADY.
- `src_hready_resp`  out  1  upstream HREADYOUT.
- `src_hresp`  out  1  upstream HRESP.
- `src_haddr`  in  W_ADDR  address.
- `src_hwrite`  in  1  write.
- `src_htrans`  in  2  transfer type.
- `src_hsize`  in  3  size.
- `src_hburst`  in  3  burst.
- `src_hprot`  in  4  protection.
- `src_hmastlock`  in  1  lock.
- `src_hwdata`  in  W_DATA  write data.
- `src_hrdata`  out  W_DATA  read data.
- `src_hexcl`  in  1  exclusive transfer flag.
- `src_hmaster`  in  8  master ID.
- `src_hexokay`  out  1  exclusive success, valid in data phase.
- `dst_hready`, `dst_haddr`, `dst_hwrite`, `dst_htrans`, `dst_hsize`, `dst_hburst`, `dst_hprot`, `dst_hmastlock`, `dst_hwdata`  out  matching widths  downstream master port.
- `dst_hready_resp`, `dst_hresp`  in  1  downstream response.
- `dst_hrdata`  in  W_DATA  downstream read data.

## Operation
- **Accept event.** An address phase is accepted when `src_hready && src_htrans[1]`.
- **Valid ID.** `id_ok = src_hmaster < N_MASTERS`.
- **Reservation table.** `resv_valid[N_MASTERS]` and `resv_addr[N_MASTERS]` (granule address). The table is updated only on the accept edge. Lookups use the pre-update state.

Per accepted transfer:
- **Exclusive read** (`hexcl && !hwrite`)
  - If `id_ok`: set `resv_valid[id]=1` and `resv_addr[id]=granule`; data-phase `hexokay=1`.
  - Else: plain read with `hexokay=0`.
- **Exclusive write** (`hexcl && hwrite`)
  - `pass = id_ok && resv_valid[id] && resv_addr[id]==granule`.
  - If pass: forward, data-phase `hexokay=1`, and clear every entry whose `resv_addr` equals the granule (own entry included).
  - If fail: drive `dst_htrans=2'b00` for that address phase, data-phase `hexokay=0`, and clear `resv_valid[id]` if `id_ok`. The write data is dropped.
- **Non-exclusive write:** see Configuration.
- **Non-exclusive read:** no table effect, `hexokay=0`.

Passthrough and response rules:
- Address-phase signals are combinational passthrough. The only exception is `dst_htrans`, which is forced to IDLE on a failed exclusive write.
- `dst_hready=src_hready`; `dst_hwdata=src_hwdata`.
- `src_hready_resp`, `src_hresp` and `src_hrdata` pass through from `dst_*`. A suppressed write sees the slave's IDLE response: zero-wait OKAY.
- **Error on exclusive read.** If a data phase with `dphase_excl_rd` set ends with `dst_hresp=1`, clear `resv_valid[dphase_id]` on that edge. If that edge also accepts a new transfer from the same master, the new transfer's update wins.

## Timing
- Data-phase registers `dphase_hexokay`, `dphase_excl_rd` and `dphase_id` load on each `src_hready` high edge. They load zero when no transfer is accepted.
- `src_hexokay = dphase_hexokay`. It is held for the whole data phase, including wait states.
- Zero added cycles on any path; the block is purely combinational forward apart from the table and data-phase registers.
- **Reset values.**
  - All `resv_valid` and data-phase registers are 0, so `src_hexokay=0`.
  - All other outputs follow their inputs.
  - Reset mid-transaction drops all reservations; the next exclusive write fails.
- **Back-to-back.** An exclusive read followed on the next accept by an exclusive write from the same master sees the just-written reservation.
- **Same-granule check.** An exclusive write from master A to granule G, with `resv_addr[B]==G`, clears B's entry on the same edge.

## Configuration
- `EXCL_MON_SNOOP_EN` defined: every accepted non-exclusive write clears all entries whose `resv_addr` equals its granule.
- Undefined: non-exclusive writes do not touch the table; only passing exclusive writes clear other masters' reservations.

## Test plan
1. **Basic pair.** M0 exclusive read 0x100, then exclusive write 0x100 data 0xA5 → both data phases `hexokay=1`; the slave receives the write; a subsequent exclusive write 0x100 fails with `dst_htrans=0` and `hexokay=0`.
2. **Contention.** M0 and M1 both exclusive-read 0x200; M1 exclusive-writes first and passes → M0's exclusive write to 0x200 fails, and memory holds M1's value.
3. **Granule.** With `GRANULE_LOG2=2`, M0 exclusive-reads 0x300, then exclusive-writes 0x302 → pass; exclusive write to 0x304 after a fresh exclusive read of 0x300 → fail.
4. **Snoop.** M0 exclusive-reads 0x400, M1 plain-writes 0x400, then M0 exclusive-writes 0x400 → fails with the macro defined, passes without it.
5. **Wait states and error.** The slave inserts 3 wait states on an exclusive read → `hexokay` stays 1 for all 4 cycles. The slave returns an ERROR on an exclusive read → the following exclusive write fails.
6. **Invalid ID and reset.** `hmaster=5` with `N_MASTERS=2`: exclusive read gives `hexokay=0`; exclusive write is suppressed. Asserting `rst_n=0` between an exclusive read and its exclusive write → the write fails.

Source files
------------

// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite global exclusive monitor: one reservation per master, hexokay reporting, failed store-conditional suppression.
// Optional snoop of plain writes into the reservation table with `define EXCL_MON_SNOOP_EN.
module ahbl_excl_monitor #(
    parameter int N_MASTERS    = 2,
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int GRANULE_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int W_GRAN = W_ADDR - GRANULE_LOG2;

    logic              resv_valid [N_MASTERS];
    logic [W_GRAN-1:0] resv_addr  [N_MASTERS];
    logic              valid_nxt  [N_MASTERS];
    logic [W_GRAN-1:0] addr_nxt   [N_MASTERS];

    logic              dphase_hexokay;
    logic              dphase_excl_rd;
    logic [IDX_W-1:0]  dphase_id;

    logic              accept;
    logic              id_ok;
    logic [IDX_W-1:0]  idx;
    logic [W_GRAN-1:0] granule;
    logic              excl_rd;
    logic              excl_wr;
    logic              pass;
    logic              fail_wr;

    assign accept  = src_hready && src_htrans[1];
    assign id_ok   = src_hmaster < 8'(N_MASTERS);
    assign idx     = src_hmaster[IDX_W-1:0];
    assign granule = src_haddr[W_ADDR-1:GRANULE_LOG2];
    assign excl_rd = accept && src_hexcl && !src_hwrite;
    assign excl_wr = accept && src_hexcl && src_hwrite;
    assign pass    = id_ok && resv_valid[idx] && (resv_addr[idx] == granule);
    assign fail_wr = excl_wr && !pass;

    assign dst_hready      = src_hready;
    assign dst_haddr       = src_haddr;
    assign dst_hwrite      = src_hwrite;
    assign dst_htrans      = fail_wr ? 2'b00 : src_htrans;
    assign dst_hsize       = src_hsize;
    assign dst_hburst      = src_hburst;
    assign dst_hprot       = src_hprot;
    assign dst_hmastlock   = src_hmastlock;
    assign dst_hwdata      = src_hwdata;
    assign src_hready_resp = dst_hready_resp;
    assign src_hresp       = dst_hresp;
    assign src_hrdata      = dst_hrdata;
    assign src_hexokay     = dphase_hexokay;

    // Error clear is applied first so a same-edge update from the new transfer overrides it.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            valid_nxt[i] = resv_valid[i];
            addr_nxt[i]  = resv_addr[i];
        end
        if (src_hready && dphase_excl_rd && dst_hresp)
            valid_nxt[dphase_id] = 1'b0;
        if (excl_rd && id_ok) begin
            valid_nxt[idx] = 1'b1;
            addr_nxt[idx]  = granule;
        end
        if (excl_wr) begin
            if (pass) begin
                for (int i = 0; i < N_MASTERS; i++)
                    if (resv_addr[i] == granule) valid_nxt[i] = 1'b0;
            end else if (id_ok) begin
                valid_nxt[idx] = 1'b0;
            end
        end
`ifdef EXCL_MON_SNOOP_EN
        if (accept && !src_hexcl && src_hwrite) begin
            for (int i = 0; i < N_MASTERS; i++)
                if (resv_addr[i] == granule) valid_nxt[i] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                resv_valid[i] <= 1'b0;
                resv_addr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                resv_valid[i] <= valid_nxt[i];
                resv_addr[i]  <= addr_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dphase_hexokay <= 1'b0;
            dphase_excl_rd <= 1'b0;
            dphase_id      <= '0;
        end else if (src_hready) begin
            dphase_hexokay <= (excl_rd && id_ok) || (excl_wr && pass);
            dphase_excl_rd <= excl_rd && id_ok;
            dphase_id      <= accept ? idx : '0;
        end
    end

endmodule
